// File: rtl/cr16_test1_checker.sv
// cr16_test1_checker
//   Response checker for cr16 datapath/ALU bring-up. Observes the control bus
//   produced by the stimulus FSM plus the datapath write-back bus, keeps a
//   shadow register file, predicts each write-back value and compares it.
//   Pass/fail status is latched for board LEDs / 7-segment display.
//
// Configuration macro:
//   CR16_CHECKER_CONTINUE_EN - when defined, mismatches are counted and
//   checking continues until I_DONE; when undefined the first mismatch
//   ends the run in FAIL. A multi-hot register enable always ends in FAIL.
//
// Ports:
//   I_CLK, I_NRESET            clock (rising edge), async active-low reset
//   I_ENABLE                   sample qualifier
//   I_OPCODE                   ALU opcode (1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR)
//   I_READ_PORT_A/B_SEL        ALU operand register indices
//   I_REG_ENABLE               one-hot register write enable
//   I_IMM_SEL, I_PRELOAD_IMM   write-back source select / preload immediate
//   I_WB_DATA                  actual datapath write-back value
//   I_DONE                     stimulus sequence finished
//   O_PASS, O_FAIL             sticky status
//   O_CHECK_COUNT              number of compared write-backs (saturating)
//   O_FAIL_COUNT               number of mismatches (saturating)
//   O_FAIL_STEP                O_CHECK_COUNT at the first mismatch
//   O_EXPECTED, O_ACTUAL       expected / observed value at the first mismatch
//   O_PROTO_ERR                failure caused by a multi-hot I_REG_ENABLE
module cr16_test1_checker #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_ENABLE,
  input  logic [3:0]            I_OPCODE,
  input  logic [3:0]            I_READ_PORT_A_SEL,
  input  logic [3:0]            I_READ_PORT_B_SEL,
  input  logic [NUM_REGS-1:0]   I_REG_ENABLE,
  input  logic                  I_IMM_SEL,
  input  logic [DATA_WIDTH-1:0] I_PRELOAD_IMM,
  input  logic [DATA_WIDTH-1:0] I_WB_DATA,
  input  logic                  I_DONE,
  output logic                  O_PASS,
  output logic                  O_FAIL,
  output logic [CNT_WIDTH-1:0]  O_CHECK_COUNT,
  output logic [CNT_WIDTH-1:0]  O_FAIL_COUNT,
  output logic [CNT_WIDTH-1:0]  O_FAIL_STEP,
  output logic [DATA_WIDTH-1:0] O_EXPECTED,
  output logic [DATA_WIDTH-1:0] O_ACTUAL,
  output logic                  O_PROTO_ERR
);

`ifdef CR16_CHECKER_CONTINUE_EN
  localparam bit CONTINUE_EN = 1'b1;
`else
  localparam bit CONTINUE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];

  logic [CNT_WIDTH-1:0]  check_count_q, check_count_d;
  logic [CNT_WIDTH-1:0]  fail_count_q,  fail_count_d;
  logic [CNT_WIDTH-1:0]  fail_step_q;
  logic [DATA_WIDTH-1:0] expected_q;
  logic [DATA_WIDTH-1:0] actual_q;
  logic                  proto_q;

  logic                  check_active;
  logic                  en_any;
  logic                  en_multi;
  logic                  wr_valid;
  logic                  proto_hit;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_known;
  logic [DATA_WIDTH-1:0] expected;
  logic                  checked;
  logic                  mismatch;
  logic                  first_fail;

  // ---------------------------------------------------------------------
  // Check-cycle qualification
  // ---------------------------------------------------------------------
  assign check_active = I_ENABLE && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign en_any       = |I_REG_ENABLE;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign en_multi     = en_any && (|(I_REG_ENABLE & (I_REG_ENABLE - NUM_REGS'(1))));
  assign wr_valid     = check_active && en_any && !en_multi;
  assign proto_hit    = check_active && en_multi;

  // Reads see the pre-edge shadow, so a same-cycle write to an operand
  // register returns the old value.
  assign op_a = shadow_q[I_READ_PORT_A_SEL];
  assign op_b = shadow_q[I_READ_PORT_B_SEL];

  // ---------------------------------------------------------------------
  // Reference ALU
  // ---------------------------------------------------------------------
  always_comb begin
    alu_res   = '0;
    alu_known = 1'b1;
    unique case (I_OPCODE)
      4'h1:    alu_res = op_a + op_b;
      4'h2:    alu_res = op_a - op_b;
      4'h3:    alu_res = op_a & op_b;
      4'h4:    alu_res = op_a | op_b;
      4'h5:    alu_res = op_a ^ op_b;
      default: alu_known = 1'b0;
    endcase
  end

  assign expected   = I_IMM_SEL ? I_PRELOAD_IMM : alu_res;
  assign checked    = wr_valid && (I_IMM_SEL || alu_known);
  assign mismatch   = checked && (I_WB_DATA != expected);
  assign first_fail = mismatch && (fail_count_q == '0);

  // Saturating counters
  always_comb begin
    check_count_d = check_count_q;
    fail_count_d  = fail_count_q;
    if (checked && (check_count_q != '1)) begin
      check_count_d = check_count_q + CNT_WIDTH'(1);
    end
    if (mismatch && (fail_count_q != '1)) begin
      fail_count_d = fail_count_q + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // I_DONE is deliberately not looked at before the run has started.
        if (check_active) begin
          if (proto_hit) begin
            state_d = S_FAIL;
          end else if (mismatch && !CONTINUE_EN) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (proto_hit) begin
          state_d = S_FAIL;
        end else if (mismatch && !CONTINUE_EN) begin
          state_d = S_FAIL;
        end else if (I_DONE) begin
          // Uses the post-update count so a mismatch coincident with
          // I_DONE still resolves to FAIL.
          state_d = (fail_count_d == '0) ? S_PASS : S_FAIL;
        end
      end
      S_PASS:  state_d = S_PASS;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    O_PASS = (state_q == S_PASS);
    O_FAIL = (state_q == S_FAIL);
  end

  // ---------------------------------------------------------------------
  // Datapath registers: counters, first-failure capture, shadow file
  // ---------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      check_count_q <= '0;
      fail_count_q  <= '0;
      fail_step_q   <= '0;
      expected_q    <= '0;
      actual_q      <= '0;
      proto_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      check_count_q <= check_count_d;
      fail_count_q  <= fail_count_d;
      if (first_fail) begin
        fail_step_q <= check_count_q;
        expected_q  <= expected;
        actual_q    <= I_WB_DATA;
      end
      if (proto_hit) begin
        proto_q <= 1'b1;
      end
      // Shadow follows the actual write-back so one bad result does not
      // cascade into later compares.
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_valid && I_REG_ENABLE[i]) begin
          shadow_q[i] <= I_WB_DATA;
        end
      end
    end
  end

  assign O_CHECK_COUNT = check_count_q;
  assign O_FAIL_COUNT  = fail_count_q;
  assign O_FAIL_STEP   = fail_step_q;
  assign O_EXPECTED    = expected_q;
  assign O_ACTUAL      = actual_q;
  assign O_PROTO_ERR   = proto_q;

endmodule

// File: tb/tb_cr16_test1_checker.sv
// Testbench for cr16_test1_checker: directed test-plan sequences followed by
// randomized episodes, all compared against a behavioural reference model.
module tb_cr16_test1_checker;

`ifdef CR16_CHECKER_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        I_CLK = 1'b0;
  logic        I_NRESET = 1'b0;
  logic        I_ENABLE = 1'b0;
  logic [3:0]  I_OPCODE = '0;
  logic [3:0]  I_READ_PORT_A_SEL = '0;
  logic [3:0]  I_READ_PORT_B_SEL = '0;
  logic [15:0] I_REG_ENABLE = '0;
  logic        I_IMM_SEL = 1'b0;
  logic [15:0] I_PRELOAD_IMM = '0;
  logic [15:0] I_WB_DATA = '0;
  logic        I_DONE = 1'b0;
  logic        O_PASS, O_FAIL, O_PROTO_ERR;
  logic [7:0]  O_CHECK_COUNT, O_FAIL_COUNT, O_FAIL_STEP;
  logic [15:0] O_EXPECTED, O_ACTUAL;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned sh [16];
  bit          m_started, m_pass, m_fail, m_proto;
  int unsigned m_cnt, m_fcnt, m_step, m_exp, m_act;

  cr16_test1_checker #(.DATA_WIDTH(16), .NUM_REGS(16), .CNT_WIDTH(8)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE),
    .I_OPCODE(I_OPCODE), .I_READ_PORT_A_SEL(I_READ_PORT_A_SEL),
    .I_READ_PORT_B_SEL(I_READ_PORT_B_SEL), .I_REG_ENABLE(I_REG_ENABLE),
    .I_IMM_SEL(I_IMM_SEL), .I_PRELOAD_IMM(I_PRELOAD_IMM), .I_WB_DATA(I_WB_DATA),
    .I_DONE(I_DONE), .O_PASS(O_PASS), .O_FAIL(O_FAIL),
    .O_CHECK_COUNT(O_CHECK_COUNT), .O_FAIL_COUNT(O_FAIL_COUNT),
    .O_FAIL_STEP(O_FAIL_STEP), .O_EXPECTED(O_EXPECTED), .O_ACTUAL(O_ACTUAL),
    .O_PROTO_ERR(O_PROTO_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) sh[i] = 0;
    m_started = 0; m_pass = 0; m_fail = 0; m_proto = 0;
    m_cnt = 0; m_fcnt = 0; m_step = 0; m_exp = 0; m_act = 0;
  endtask

  // Expected write-back straight from the opcode table, 16-bit wrap.
  function automatic int unsigned model_exp(input int unsigned op, input int unsigned a,
                                            input int unsigned b, input bit isel,
                                            input int unsigned imm, output bit known);
    int unsigned x = sh[a];
    int unsigned y = sh[b];
    known = 1;
    if (isel) return imm;
    case (op)
      1: return (x + y) % 65536;
      2: return (x + 65536 - y) % 65536;
      3: return x & y;
      4: return x | y;
      5: return x ^ y;
      default: begin known = 0; return 0; end
    endcase
  endfunction

  task automatic model_step(input bit en, input int unsigned op, input int unsigned a,
                            input int unsigned b, input int unsigned re, input bit isel,
                            input int unsigned imm, input int unsigned wb, input bit dn);
    bit was_started = m_started;
    bit known;
    int unsigned e;
    int nbits = $countones(re);
    int idx = 0;
    if (m_pass || m_fail) return;
    if (en) begin
      m_started = 1;
      if (nbits > 1) begin
        m_proto = 1; m_fail = 1;
        return;
      end
      if (nbits == 1) begin
        for (int i = 0; i < 16; i++) if (re == (1 << i)) idx = i;
        e = model_exp(op, a, b, isel, imm, known);
        if (known) begin
          if (m_cnt < 255) m_cnt++;
          if (wb != e) begin
            if (m_fcnt == 0) begin m_step = m_cnt - 1; m_exp = e; m_act = wb; end
            if (m_fcnt < 255) m_fcnt++;
            if (!CONT) m_fail = 1;
          end
        end
        sh[idx] = wb;
      end
    end
    if (was_started && !m_fail && dn) begin
      if (m_fcnt == 0) m_pass = 1; else m_fail = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pass"},  32'(O_PASS),        32'(m_pass));
    chk({tag, ".fail"},  32'(O_FAIL),        32'(m_fail));
    chk({tag, ".proto"}, 32'(O_PROTO_ERR),   32'(m_proto));
    chk({tag, ".cnt"},   32'(O_CHECK_COUNT), m_cnt);
    chk({tag, ".fcnt"},  32'(O_FAIL_COUNT),  m_fcnt);
    chk({tag, ".step"},  32'(O_FAIL_STEP),   m_step);
    chk({tag, ".exp"},   32'(O_EXPECTED),    m_exp);
    chk({tag, ".act"},   32'(O_ACTUAL),      m_act);
  endtask

  task automatic step(input string tag, input bit en, input int unsigned op,
                      input int unsigned a, input int unsigned b, input int unsigned re,
                      input bit isel, input int unsigned imm, input int unsigned wb,
                      input bit dn);
    @(negedge I_CLK);
    I_ENABLE = en; I_OPCODE = 4'(op); I_READ_PORT_A_SEL = 4'(a);
    I_READ_PORT_B_SEL = 4'(b); I_REG_ENABLE = 16'(re); I_IMM_SEL = isel;
    I_PRELOAD_IMM = 16'(imm); I_WB_DATA = 16'(wb); I_DONE = dn;
    @(posedge I_CLK);
    model_step(en, op, a, b, re, isel, imm, wb, dn);
    #1;
    check_all(tag);
    I_ENABLE = 0; I_DONE = 0; I_REG_ENABLE = '0;
  endtask

  task automatic do_reset();
    @(negedge I_CLK);
    I_NRESET = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge I_CLK);
    I_NRESET = 1;
  endtask

  task automatic preload01(input int unsigned v0, input int unsigned v1);
    step("pre_r0", 1, 0, 0, 0, 16'h0001, 1, v0, v0, 0);
    step("pre_r1", 1, 0, 0, 0, 16'h0002, 1, v1, v1, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("por");
    do_reset();

    // Plan 1: clean preload + ADD + done
    preload01(1, 1);
    step("add_ok", 1, 1, 0, 1, 16'h0004, 0, 0, 16'h0002, 0);
    step("done_ok", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("p1.pass", 32'(O_PASS), 1);
    chk("p1.cnt", 32'(O_CHECK_COUNT), 3);
    chk("p1.fcnt", 32'(O_FAIL_COUNT), 0);

    // Plan 2: mismatching ADD
    do_reset();
    preload01(1, 1);
    step("add_bad", 1, 1, 0, 1, 16'h0004, 0, 0, 16'h0003, 0);
    step("done_bad", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("p2.fail", 32'(O_FAIL), 1);
    chk("p2.step", 32'(O_FAIL_STEP), 2);
    chk("p2.exp", 32'(O_EXPECTED), 16'h0002);
    chk("p2.act", 32'(O_ACTUAL), 16'h0003);

    // Plan 3: ADD wraparound
    do_reset();
    preload01(16'hFFFF, 1);
    step("add_wrap", 1, 1, 0, 1, 16'h0004, 0, 0, 16'h0000, 0);
    chk("p3.fail", 32'(O_FAIL), 0);
    chk("p3.fcnt", 32'(O_FAIL_COUNT), 0);

    // Plan 4: multi-hot enable
    step("proto", 1, 1, 0, 1, 16'h0003, 0, 0, 16'h1234, 0);
    chk("p4.proto", 32'(O_PROTO_ERR), 1);
    chk("p4.fail", 32'(O_FAIL), 1);
    chk("p4.cnt", 32'(O_CHECK_COUNT), 3);

    // Plan 5: two mismatches then done
    do_reset();
    preload01(5, 3);
    step("mm1", 1, 1, 0, 1, 16'h0004, 0, 0, 16'h0009, 0);
    step("mm2", 1, 2, 0, 1, 16'h0008, 0, 0, 16'h0007, 0);
    step("mm_done", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("p5.fail", 32'(O_FAIL), 1);
    chk("p5.fcnt", 32'(O_FAIL_COUNT), CONT ? 2 : 1);
    chk("p5.exp", 32'(O_EXPECTED), 8);

    // Plan 6: asynchronous reset mid-sequence, then shadow file is zero
    do_reset();
    preload01(16'h00AA, 16'h0055);
    #3;
    I_NRESET = 0;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge I_CLK);
    I_NRESET = 1;
    step("zero_add", 1, 1, 0, 1, 16'h0004, 0, 0, 16'h0000, 0);
    step("zero_xor", 1, 5, 7, 15, 16'h0008, 0, 0, 16'h0000, 0);
    chk("p6.fcnt", 32'(O_FAIL_COUNT), 0);

    // Randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int s = 0; s < 60; s++) begin
        int unsigned op   = $urandom_range(0, 7);
        int unsigned a    = $urandom_range(0, 15);
        int unsigned b    = $urandom_range(0, 15);
        int unsigned isel = ($urandom_range(0, 2) == 0) ? 1 : 0;
        int unsigned imm  = $urandom_range(0, 65535);
        int unsigned r    = $urandom_range(0, 99);
        int unsigned bi   = $urandom_range(0, 15);
        int unsigned re;
        int unsigned wb;
        int unsigned e;
        bit known;
        bit en = ($urandom_range(0, 9) != 0);
        if (r < 6) re = 0;
        else if (ep == 5 && r < 9) re = (1 << bi) | (1 << ((bi + 1 + $urandom_range(0, 14)) % 16));
        else re = 1 << bi;
        e = model_exp(op, a, b, isel[0], imm, known);
        if (!known) wb = $urandom_range(0, 65535);
        else if ($urandom_range(0, 99) < ep * 2) wb = e ^ $urandom_range(1, 65535);
        else wb = e;
        step("rnd", en, op, a, b, re, isel[0], imm, wb, 0);
      end
      step("rnd_done", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cr16_test1_checker.md
Name: cr16_test1_checker

Overview:
- Response checker for the cr16 datapath/ALU bring-up. It is the receiving end of the stimulus FSM's control bus.
- Watches the opcode, read-port selects, register write enables and preload immediate driven into the datapath, plus the datapath write-back bus.
- Keeps a shadow register file, computes the expected write-back value and compares it every cycle.
- Latches pass/fail status for board LEDs / 7-segment display.

Parameters:
- DATA_WIDTH, 16, register and ALU data width.
- NUM_REGS, 16, register count; equals the width of I_REG_ENABLE.
- CNT_WIDTH, 8, width of the check and fail counters.

Ports:
- I_CLK  in  1  system clock, rising edge.
- I_NRESET  in  1  asynchronous, active-low reset.
- I_ENABLE  in  1  sample qualifier; nothing is checked while low.
- I_OPCODE  in  4  ALU opcode driven to the datapath.
- I_READ_PORT_A_SEL  in  4  register index on ALU port A.
- I_READ_PORT_B_SEL  in  4  register index on ALU port B.
- I_REG_ENABLE  in  NUM_REGS  one-hot register write enable.
- I_IMM_SEL  in  1  1 = write-back source is I_PRELOAD_IMM, 0 = ALU result.
- I_PRELOAD_IMM  in  DATA_WIDTH  preload immediate.
- I_WB_DATA  in  DATA_WIDTH  value the datapath is actually writing this cycle.
- I_DONE  in  1  stimulus sequence finished.
- O_PASS  out  1  sequence completed with zero mismatches.
- O_FAIL  out  1  mismatch or protocol error detected.
- O_CHECK_COUNT  out  CNT_WIDTH  number of write-backs compared.
- O_FAIL_COUNT  out  CNT_WIDTH  number of mismatches.
- O_FAIL_STEP  out  CNT_WIDTH  O_CHECK_COUNT value at the first failure.
- O_EXPECTED  out  DATA_WIDTH  expected value at the first failure.
- O_ACTUAL  out  DATA_WIDTH  I_WB_DATA at the first failure.
- O_PROTO_ERR  out  1  failure was caused by a multi-hot I_REG_ENABLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (I_CLK, I_NRESET).
  - On reset: all outputs 0, shadow registers 0, state IDLE.
- States:
  - IDLE: go to RUN on the first cycle with I_ENABLE=1; that cycle is also checked.
  - RUN: check every cycle with I_ENABLE=1. I_DONE=1 goes to PASS if O_FAIL_COUNT=0, else FAIL.
  - PASS: sticky until reset. O_PASS=1.
  - FAIL: sticky until reset. O_FAIL=1.
- Check cycle (RUN, or IDLE with I_ENABLE):
  - I_REG_ENABLE = 0: no compare, no counter change.
  - I_REG_ENABLE multi-hot: O_PROTO_ERR=1, go to FAIL, no compare.
  - I_REG_ENABLE one-hot, compare source:
    - I_IMM_SEL=1: expected = I_PRELOAD_IMM.
    - I_IMM_SEL=0: expected = f(opcode, shadow[A], shadow[B]).
  - Opcodes: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR. ADD/SUB wrap modulo 2^DATA_WIDTH.
  - Any other opcode with I_IMM_SEL=0 is unchecked: the shadow is updated, nothing is counted.
  - Checked write: O_CHECK_COUNT increments, saturating at all-ones.
  - Mismatch: O_FAIL_COUNT increments, saturating. On the first mismatch only, capture O_FAIL_STEP (pre-increment count), O_EXPECTED and O_ACTUAL.
- Shadow register update:
  - On every one-hot write, the shadow register is loaded with I_WB_DATA (the actual value), so one error does not cascade.
  - A read of the register being written in the same cycle returns the old shadow value.
- Latency: status outputs, counters and captured values update on the I_CLK edge that samples the write. They are visible the following cycle.
- Simultaneous events:
  - A mismatch together with I_DONE in the same cycle resolves to FAIL.
  - I_DONE in IDLE is ignored.
- Reset mid-sequence aborts immediately and clears everything.

Optional Feature:
- CR16_CHECKER_CONTINUE_EN
  - Defined: a mismatch stays in RUN and checking continues. FAIL is entered at I_DONE if O_FAIL_COUNT > 0. O_FAIL asserts only in FAIL.
  - Undefined: the first mismatch goes to FAIL on that edge and checking stops. O_FAIL_COUNT saturates at 1.
  - O_PROTO_ERR always goes to FAIL immediately, with or without the macro.

Test Plan:
- Preload 0x0001 to r0 (REG_ENABLE 0x0001) and to r1 (0x0002). Then ADD A=0,B=1, REG_ENABLE 0x0004, WB 0x0002, then I_DONE -> O_PASS=1, O_CHECK_COUNT=3, O_FAIL_COUNT=0.
- Same sequence but WB 0x0003 on the ADD step -> O_FAIL=1 next cycle, O_FAIL_STEP=2, O_EXPECTED=0x0002, O_ACTUAL=0x0003.
- Preload r0=0xFFFF and r1=0x0001, then ADD to r2 with WB 0x0000 -> no failure; wraparound accepted.
- REG_ENABLE 0x0003 with I_ENABLE=1 -> O_PROTO_ERR=1, O_FAIL=1, counters unchanged.
- Two mismatching ADDs, then I_DONE:
  - with CONTINUE_EN: stays in RUN until I_DONE, then O_FAIL_COUNT=2 and O_FAIL=1.
  - without: O_FAIL after the first mismatch, O_FAIL_COUNT=1.
- Assert I_NRESET low mid-sequence between clock edges -> all outputs 0 immediately; after release, state IDLE and shadow registers 0.
